du_program_loader: RTL and testbench
====================================

Name: du_program_loader

Overview:
Debug-unit side of the instruction-memory load interface. Receives a byte stream from the UART receiver, assembles big-endian 32-bit instruction words, and drives the pipeline's debug-unit data/address/write-enable/read-enable inputs to fill instruction memory. It reports the load result to the UART transmitter with an ACK/NAK byte, then releases the pipeline to fetch. It sits between the UART RX/TX blocks and the pipeline top.

Parameters:
IMEM_DEPTH, 256, instruction memory depth in words; must be a power of 2.
HALT_WORD, 32'hFFFF_FFFF, end-of-program marker; it is written to memory and terminates the load.
CMD_LOAD, 8'h4C, command byte that starts a load.
ACK_BYTE, 8'h06, TX byte sent on success.
NAK_BYTE, 8'h15, TX byte sent on error.

Ports:
i_clk  in  1  system clock; all state updates on rising edge.
i_reset  in  1  asynchronous, active-high reset.
i_rx_data  in  8  received byte.
i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid in that cycle.
i_tx_done  in  1  one-cycle strobe from the transmitter when the byte has been sent.
o_tx_data  out  8  byte to transmit.
o_tx_start  out  1  one-cycle request to the transmitter.
o_du_data  out  32  instruction word to write.
o_du_addr_wr  out  32  byte address of the write; always word aligned.
o_du_write_en  out  1  one-cycle instruction-memory write strobe.
o_du_read_en  out  1  enables pipeline fetch; high only in S_RUN.
o_word_count  out  $clog2(IMEM_DEPTH)+1  number of words written in the current or last load.
o_error  out  1  sticky overflow/checksum error for the last load.

Behaviour:
- Reset (async):
  - State returns to S_IDLE.
  - All outputs are 0.
  - Byte index and partial word are cleared.
  - Reset mid-load discards the partial word; memory contents already written are not touched.
- States: S_IDLE, S_RECV, S_WRITE, S_ACK_REQ, S_ACK_WAIT, S_RUN.
- S_IDLE:
  - o_du_read_en = 0.
  - i_rx_valid with CMD_LOAD goes to S_RECV and clears addr, word_count, byte index and o_error.
  - Any other byte is ignored.
- S_RECV: each i_rx_valid shifts the byte into the word.
  - First byte goes to [31:24], last byte to [7:0].
  - On the 4th byte, o_du_data is loaded with the full word and the state goes to S_WRITE.
- S_WRITE (exactly 1 cycle): o_du_write_en = 1, with o_du_data and o_du_addr_wr stable.
  - The 4th byte is accepted in cycle N; write_en is high in cycle N+1.
  - At the end of the cycle: addr += 4, word_count += 1.
  - If the word == HALT_WORD, go to S_ACK_REQ; otherwise go to S_RECV.
  - A byte arriving during S_WRITE is captured as byte 0 of the next word and is never dropped.
- Overflow: if word_count == IMEM_DEPTH when a 4th byte completes, there is no write.
  - o_error is set and the state goes to S_ACK_REQ.
  - Address never wraps.
- S_ACK_REQ (1 cycle): o_tx_start = 1, with o_tx_data = NAK_BYTE if o_error, else ACK_BYTE. Then S_ACK_WAIT.
- S_ACK_WAIT: wait for i_tx_done.
  - On i_tx_done, go to S_IDLE if o_error, else S_RUN.
  - RX bytes in S_ACK_REQ and S_ACK_WAIT are ignored.
- S_RUN: o_du_read_en = 1.
  - CMD_LOAD drops read_en in the next cycle and re-enters S_RECV with the same clearing as from S_IDLE.
  - Other bytes are ignored.
- o_du_write_en and o_tx_start are never high together and are never high for more than 1 cycle.

Optional Feature:
Macro DU_LOADER_CHECKSUM_EN.
- When defined: after HALT_WORD is written, the FSM expects one further byte equal to the XOR of every received program byte, including the halt-word bytes and excluding CMD_LOAD.
  - A mismatch sets o_error, so a NAK is sent.
  - A new state, S_CSUM, sits between S_WRITE and S_ACK_REQ.
- When undefined: there is no checksum byte, and HALT_WORD goes directly to S_ACK_REQ.

Decomposition:
- Package du_pkg holds:
  - the state enum encodings;
  - CMD_LOAD, ACK_BYTE and NAK_BYTE defaults;
  - the HALT_WORD default.
- One sub-module, du_word_assembler, is natural. It contains:
  - the byte shift register and 2-bit byte index;
  - the "word complete" pulse;
  - a synchronous clear input, used on CMD_LOAD.

Test Plan:
- Basic load: send 4C, 20 08 00 05, FF FF FF FF, then pulse i_tx_done.
  - Write 1: data=0x20080005, addr=0. Write 2: data=0xFFFFFFFF, addr=4.
  - tx_data=0x06, then read_en=1 and word_count=2.
- Back-to-back: a byte arrives in the S_WRITE cycle. That byte appears as [31:24] of the next word; no byte is lost.
- Overflow with IMEM_DEPTH=4: send 5 non-halt words.
  - Exactly 4 writes (addr 0,4,8,12); the 5th word is not written.
  - o_error=1, tx_data=0x15, and the block returns to S_IDLE with read_en=0.
- Reset mid-word: send 4C, AA, BB, then assert i_reset.
  - All outputs are 0.
  - Then 4C, 01 02 03 04 produces a write of 0x01020304 at addr 0.
- Reload from run: complete a load, then in S_RUN send 4C.
  - read_en drops 1 cycle later.
  - The next word writes at addr 0 and word_count restarts from 0.
- Ignored bytes: sending 0x00 and 0x52 in S_IDLE causes no writes and no state change.

Source files
------------

// File: rtl/du_pkg.sv
// Shared constants for the debug-unit program loader: FSM state encodings,
// default command/response bytes and the end-of-program marker.
package du_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RECV     = 3'd1;
    localparam logic [2:0] S_WRITE    = 3'd2;
    localparam logic [2:0] S_ACK_REQ  = 3'd3;
    localparam logic [2:0] S_ACK_WAIT = 3'd4;
    localparam logic [2:0] S_RUN      = 3'd5;
    localparam logic [2:0] S_CSUM     = 3'd6;

    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
    localparam logic [7:0]  CMD_LOAD_DEF  = 8'h4C;
    localparam logic [7:0]  ACK_BYTE_DEF  = 8'h06;
    localparam logic [7:0]  NAK_BYTE_DEF  = 8'h15;

    function automatic logic [7:0] resp_byte(input logic err,
                                             input logic [7:0] ack,
                                             input logic [7:0] nak);
        return err ? nak : ack;
    endfunction

endpackage

// File: rtl/du_if.sv
// Bundle of the UART-side and pipeline-side signals of the program loader.
// master = the loader, slave = the surrounding UART/pipeline logic.
interface du_if #(
    parameter int IMEM_DEPTH = 256
) ();
    localparam int CW = $clog2(IMEM_DEPTH) + 1;

    logic [7:0]    i_rx_data;
    logic          i_rx_valid;
    logic          i_tx_done;
    logic [7:0]    o_tx_data;
    logic          o_tx_start;
    logic [31:0]   o_du_data;
    logic [31:0]   o_du_addr_wr;
    logic          o_du_write_en;
    logic          o_du_read_en;
    logic [CW-1:0] o_word_count;
    logic          o_error;

    modport master (
        input  i_rx_data, i_rx_valid, i_tx_done,
        output o_tx_data, o_tx_start, o_du_data, o_du_addr_wr,
               o_du_write_en, o_du_read_en, o_word_count, o_error
    );

    modport slave (
        output i_rx_data, i_rx_valid, i_tx_done,
        input  o_tx_data, o_tx_start, o_du_data, o_du_addr_wr,
               o_du_write_en, o_du_read_en, o_word_count, o_error
    );

endinterface

// File: rtl/du_word_assembler.sv
// Packs a byte stream into big-endian 32-bit words; word_done pulses in the
// same cycle the 4th byte is presented, with word valid alongside it.
module du_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        word      = {shift_q, byte_in};
        word_done = byte_vld && (idx_q == 2'd3);
        shift_d   = shift_q;
        idx_d     = idx_q;
        if (clr) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (byte_vld) begin
            // idx wraps 3 -> 0 so the next byte lands in [31:24]
            idx_d   = idx_q + 2'd1;
            shift_d = word_done ? '0 : {shift_q[15:0], byte_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/du_program_loader.sv
// Debug-unit program loader: UART bytes -> instruction-memory writes, then
// ACK/NAK and release of the pipeline. Optional trailing checksum byte is
// enabled by defining DU_LOADER_CHECKSUM_EN.
module du_program_loader
    import du_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] HALT_WORD  = HALT_WORD_DEF,
    parameter logic [7:0]  CMD_LOAD   = CMD_LOAD_DEF,
    parameter logic [7:0]  ACK_BYTE   = ACK_BYTE_DEF,
    parameter logic [7:0]  NAK_BYTE   = NAK_BYTE_DEF
) (
    input logic  i_clk,
    input logic  i_reset,
    du_if.master bus
);

    localparam int CW = $clog2(IMEM_DEPTH) + 1;
`ifdef DU_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic [2:0]    state_q, state_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] wc_q, wc_d;
    logic          err_q, err_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [7:0]    csum_q, csum_d;

    logic        asm_clr, asm_vld, asm_done;
    logic [31:0] asm_word;
    logic        rx_cmd, csum_bad;

    du_word_assembler u_asm (
        .clk       (i_clk),
        .rst       (i_reset),
        .clr       (asm_clr),
        .byte_vld  (asm_vld),
        .byte_in   (bus.i_rx_data),
        .word      (asm_word),
        .word_done (asm_done)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        addr_d    = addr_q;
        wc_d      = wc_q;
        err_d     = err_q;
        tx_data_d = tx_data_q;
        csum_d    = csum_q;
        asm_clr   = 1'b0;
        asm_vld   = 1'b0;
        rx_cmd    = bus.i_rx_valid && (bus.i_rx_data == CMD_LOAD);
        csum_bad  = bus.i_rx_data != csum_q;

        case (state_q)
            S_IDLE, S_RUN: begin
                if (rx_cmd) begin
                    state_d = S_RECV;
                    addr_d  = '0;
                    wc_d    = '0;
                    err_d   = 1'b0;
                    csum_d  = '0;
                    asm_clr = 1'b1;
                end
            end
            S_RECV: begin
                asm_vld = bus.i_rx_valid;
                if (bus.i_rx_valid) csum_d = csum_q ^ bus.i_rx_data;
                if (asm_done) begin
                    if (wc_q == CW'(IMEM_DEPTH)) begin
                        err_d     = 1'b1;
                        tx_data_d = NAK_BYTE;
                        state_d   = S_ACK_REQ;
                    end else begin
                        data_d  = asm_word;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                addr_d = addr_q + 32'd4;
                wc_d   = wc_q + CW'(1);
                if (data_q == HALT_WORD) begin
                    if (!CSUM_EN) begin
                        tx_data_d = resp_byte(err_q, ACK_BYTE, NAK_BYTE);
                        state_d   = S_ACK_REQ;
                    end else if (bus.i_rx_valid) begin
                        // checksum byte may arrive back-to-back with the halt write
                        err_d     = csum_bad;
                        tx_data_d = resp_byte(csum_bad, ACK_BYTE, NAK_BYTE);
                        state_d   = S_ACK_REQ;
                    end else begin
                        state_d = S_CSUM;
                    end
                end else begin
                    asm_vld = bus.i_rx_valid;
                    if (bus.i_rx_valid) csum_d = csum_q ^ bus.i_rx_data;
                    state_d = S_RECV;
                end
            end
            S_CSUM: begin
                if (bus.i_rx_valid) begin
                    err_d     = csum_bad;
                    tx_data_d = resp_byte(csum_bad, ACK_BYTE, NAK_BYTE);
                    state_d   = S_ACK_REQ;
                end
            end
            S_ACK_REQ: state_d = S_ACK_WAIT;
            S_ACK_WAIT: begin
                if (bus.i_tx_done) state_d = err_q ? S_IDLE : S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            addr_q    <= '0;
            wc_q      <= '0;
            err_q     <= 1'b0;
            tx_data_q <= '0;
            csum_q    <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            wc_q      <= wc_d;
            err_q     <= err_d;
            tx_data_q <= tx_data_d;
            csum_q    <= csum_d;
        end
    end

    // strobes decode straight from the state so they are single-cycle and exclusive
    assign bus.o_du_write_en = (state_q == S_WRITE);
    assign bus.o_tx_start    = (state_q == S_ACK_REQ);
    assign bus.o_du_read_en  = (state_q == S_RUN);
    assign bus.o_tx_data     = tx_data_q;
    assign bus.o_du_data     = data_q;
    assign bus.o_du_addr_wr  = addr_q;
    assign bus.o_word_count  = wc_q;
    assign bus.o_error       = err_q;

endmodule

// File: tb/tb_du_program_loader.sv
// Directed self-checking bench for du_program_loader (IMEM_DEPTH = 4).
module tb_du_program_loader;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    du_if #(.IMEM_DEPTH(4)) bus ();
    du_program_loader #(.IMEM_DEPTH(4)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.master)
    );

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          tx_cnt = 0;
    logic [7:0]  last_tx = 8'h00;
    int          overlap = 0;
    int          long_pulse = 0;
    logic        we_prev = 1'b0;
    logic        ts_prev = 1'b0;
    logic [7:0]  csum = 8'h00;

    always @(negedge clk) begin
        if (bus.o_du_write_en) begin
            wr_addr.push_back(bus.o_du_addr_wr);
            wr_data.push_back(bus.o_du_data);
        end
        if (bus.o_tx_start) begin
            tx_cnt++;
            last_tx = bus.o_tx_data;
        end
        if (bus.o_du_write_en && bus.o_tx_start) overlap++;
        if ((bus.o_du_write_en && we_prev) || (bus.o_tx_start && ts_prev)) long_pulse++;
        we_prev = bus.o_du_write_en;
        ts_prev = bus.o_tx_start;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int i);
        return (i < wr_data.size()) ? wr_data[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] wa(input int i);
        return (i < wr_addr.size()) ? wr_addr[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic drive(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.i_rx_data  = b;
        bus.i_rx_valid = 1'b1;
        csum           = csum ^ b;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive(b);
        idle();
    endtask

    task automatic send_cmd();
        send_byte(8'h4C);
        csum = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic end_load();
`ifdef DU_LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = csum;
        send_byte(c);
`endif
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        @(posedge clk);
        #1 bus.i_tx_done = 1'b1;
        @(posedge clk);
        #1 bus.i_tx_done = 1'b0;
    endtask

    int wb;
    int tb0;

    initial begin
        rst            = 1'b1;
        bus.i_rx_data  = 8'h00;
        bus.i_rx_valid = 1'b0;
        bus.i_tx_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobes", {28'd0, bus.o_du_write_en, bus.o_du_read_en, bus.o_tx_start, bus.o_error}, 32'd0);
        check("rst_data", bus.o_du_data | bus.o_du_addr_wr | {24'd0, bus.o_tx_data}, 32'd0);
        check("rst_wc", {29'd0, bus.o_word_count}, 32'd0);
        rst = 1'b0;

        // bytes other than CMD_LOAD are ignored in idle
        wb = wr_data.size();
        send_byte(8'h00);
        send_byte(8'h52);
        send_word(32'h11223344);
        repeat (3) @(posedge clk);
        #1;
        check("ign_writes", wr_data.size() - wb, 0);
        check("ign_read_en", {31'd0, bus.o_du_read_en}, 32'd0);

        // basic load
        wb = wr_data.size();
        tb0 = tx_cnt;
        send_cmd();
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        check("we_latency", {31'd0, bus.o_du_write_en}, 32'd1);
        send_word(32'hFFFF_FFFF);
        end_load();
        check("basic_nwr", wr_data.size() - wb, 2);
        check("basic_d0", wd(wb), 32'h2008_0005);
        check("basic_a0", wa(wb), 32'd0);
        check("basic_d1", wd(wb+1), 32'hFFFF_FFFF);
        check("basic_a1", wa(wb+1), 32'd4);
        check("basic_ntx", tx_cnt - tb0, 1);
        check("basic_tx", {24'd0, last_tx}, 32'h06);
        check("basic_wait_re", {31'd0, bus.o_du_read_en}, 32'd0);
        pulse_done();
        check("basic_re", {31'd0, bus.o_du_read_en}, 32'd1);
        check("basic_wc", {29'd0, bus.o_word_count}, 32'd2);
        check("basic_err", {31'd0, bus.o_error}, 32'd0);

        // reload from run: read_en drops one cycle after CMD_LOAD
        wb = wr_data.size();
        drive(8'h4C);
        check("reload_re_hold", {31'd0, bus.o_du_read_en}, 32'd1);
        idle();
        csum = 8'h00;
        check("reload_re_drop", {31'd0, bus.o_du_read_en}, 32'd0);
        check("reload_wc0", {29'd0, bus.o_word_count}, 32'd0);
        send_word(32'hDEAD_BEEF);
        send_word(32'hFFFF_FFFF);
        end_load();
        check("reload_d0", wd(wb), 32'hDEAD_BEEF);
        check("reload_a0", wa(wb), 32'd0);
        pulse_done();
        check("reload_wc", {29'd0, bus.o_word_count}, 32'd2);

        // back-to-back: 0xA5 arrives in the write cycle of the first word
        wb = wr_data.size();
        send_cmd();
        drive(8'h01); drive(8'h02); drive(8'h03); drive(8'h04);
        drive(8'hA5); drive(8'h06); drive(8'h07); drive(8'h08);
        idle();
        send_word(32'hFFFF_FFFF);
        end_load();
        check("b2b_nwr", wr_data.size() - wb, 3);
        check("b2b_d0", wd(wb), 32'h0102_0304);
        check("b2b_d1", wd(wb+1), 32'hA506_0708);
        check("b2b_a1", wa(wb+1), 32'd4);
        check("b2b_a2", wa(wb+2), 32'd8);
        pulse_done();
        check("b2b_wc", {29'd0, bus.o_word_count}, 32'd3);

        // reset mid-word
        send_cmd();
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        #2;
        check("mrst_strobes", {28'd0, bus.o_du_write_en, bus.o_du_read_en, bus.o_tx_start, bus.o_error}, 32'd0);
        check("mrst_data", bus.o_du_data, 32'd0);
        check("mrst_tx", {24'd0, bus.o_tx_data}, 32'd0);
        check("mrst_addr_wc", bus.o_du_addr_wr | {29'd0, bus.o_word_count}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // fresh load after reset doubles as the overflow run (depth 4)
        wb = wr_data.size();
        tb0 = tx_cnt;
        send_cmd();
        send_word(32'h0102_0304);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        send_word(32'h3333_3333);
        send_word(32'h4444_4444);
        repeat (4) @(posedge clk);
        #1;
        check("ovf_d0", wd(wb), 32'h0102_0304);
        check("ovf_a0", wa(wb), 32'd0);
        check("ovf_nwr", wr_data.size() - wb, 4);
        check("ovf_a3", wa(wb+3), 32'd12);
        check("ovf_d3", wd(wb+3), 32'h3333_3333);
        check("ovf_err", {31'd0, bus.o_error}, 32'd1);
        check("ovf_ntx", tx_cnt - tb0, 1);
        check("ovf_tx", {24'd0, last_tx}, 32'h15);
        check("ovf_wc", {29'd0, bus.o_word_count}, 32'd4);
        pulse_done();
        repeat (2) @(posedge clk);
        #1;
        check("ovf_re", {31'd0, bus.o_du_read_en}, 32'd0);
        wb = wr_data.size();
        send_word(32'h5555_5555);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_idle_nwr", wr_data.size() - wb, 0);
        check("ovf_err_sticky", {31'd0, bus.o_error}, 32'd1);

        check("strobe_overlap", overlap, 0);
        check("strobe_long", long_pulse, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
